mcpu_int_ctrl: RTL and testbench
================================

# mcpu_int_ctrl

Parametrised interrupt controller for the multi-cycle CPU. Its `int_req` output drives the CPU top's `INT` input. The block gathers up to `N_SRC` interrupt sources, each with its own mask and its own edge/level mode, and picks one by fixed priority. It presents a latched vector to the CPU and runs an ack / end-of-interrupt handshake. Configuration registers are written and read over a small word-addressed port decoded off the CPU data bus.

## Interface
- `N_SRC`, default 8: number of interrupt sources. Legal range 1..32.
- `VEC_W`, default 3: vector width. Must satisfy 2^VEC_W >= N_SRC.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-low reset. `reset`=0 at a rising edge resets the block.
- `irq_in`  in  N_SRC: interrupt sources, already synchronous to `clk`.
- `cfg_we`  in  1: configuration write strobe.
- `cfg_addr`  in  2: register select. 0=MASK, 1=MODE, 2=PEND, 3=STAT.
- `cfg_wdata`  in  32: write data.
- `cfg_rdata`  out  32: registered read data for `cfg_addr`.
- `int_req`  out  1: interrupt request to the CPU `INT` input.
- `int_vec`  out  VEC_W: index of the requested or in-service source.
- `int_ack`  in  1: one-cycle pulse; the CPU accepts the request.
- `int_eoi`  in  1: one-cycle pulse; the handler has finished.
- `busy`  out  1: an interrupt is in service.

## Operation
- **Registers.** Only bits [N_SRC-1:0] are implemented. Unused bits read 0 and writes to them are ignored.
  - MASK: 1 = source masked.
  - MODE: 1 = edge, 0 = level.
  - PEND: read shows the pending bits. Write-1-to-clear, effective only on edge-mode bits.
  - STAT: read-only. Bit 31 = in service; bits [VEC_W-1:0] = `int_vec`.
- **Pending logic.** `irq_d` is the registered `irq_in`.
  - Edge-mode bit: set when `irq_in & ~irq_d`. Cleared by a PEND W1C write or by `int_ack` for that vector.
  - Level-mode bit: equals `irq_d`.
  - Set has priority over every clear in the same cycle.
- **Eligibility.** `elig = PEND & ~MASK`. Priority is fixed: the lowest index wins.
- **FSM, IDLE.**
  - If `elig` is non-zero: latch `int_vec` = lowest set index, assert `int_req`, go to REQ.
- **FSM, REQ.**
  - `int_vec` is frozen and `int_req` is held at 1.
  - On `int_ack`: clear the edge pending bit of `int_vec` (if that source is edge mode), set `int_req`=0, go to SERVICE.
  - Else, if `elig[int_vec]` has dropped (level deasserted, masked, or W1C'd): retract. Set `int_req`=0, go to IDLE. A new arbitration is allowed the following cycle.
  - `int_ack` beats retraction when both occur in the same cycle.
- **FSM, SERVICE.**
  - `busy`=1 and `int_vec` is held.
  - New pending bits accumulate. There is no nesting.
  - On `int_eoi`: go to IDLE.
- **Ignored inputs.** `int_ack` outside REQ and `int_eoi` outside SERVICE have no effect.
- **MODE changes.** A change of MODE takes effect on the next cycle's pending computation. Edge bits already latched are kept until cleared.

## Timing
- **Reset values.** On the cycle after a rising edge with `reset`=0:
  - `int_req`=0, `int_vec`=0, `busy`=0, `cfg_rdata`=0.
  - MASK = all implemented bits 1. MODE=0, PEND=0, `irq_d`=0.
  - State = IDLE.
  - Reset mid-handshake drops the request immediately; no ack or eoi is expected afterwards.
- **Request latency.** If `irq_in` rises and is sampled at edge k, then PEND is set after edge k and `int_req`=1 after edge k+1. This assumes the source is unmasked and the FSM is in IDLE.
- **Ack.** With `int_ack` at edge m: `int_req`=0 and `busy`=1 after edge m.
- **Eoi.** With `int_eoi` at edge m: `busy`=0 after edge m. Earliest next `int_req` is after edge m+1.
- **Config writes** take effect after the write edge. They affect arbitration in the next cycle.
- **Reads.** `cfg_rdata` is updated every edge from `cfg_addr`: one-cycle latency, no read strobe. A same-cycle write and read of one register returns the old value.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles with `irq_in`=0xFF. Required: `int_req`=0, then a read of MASK returns 0x000000FF, then a read of PEND returns 0x000000FF (level mode).
- **Edge priority.** Write MASK=0 and MODE=0xFF, then pulse `irq_in`[5] and `irq_in`[2] in the same cycle. Required:
  - `int_req` two cycles later with `int_vec`=2.
  - Ack then eoi → next `int_vec`=5.
  - Ack then eoi → PEND=0.
- **Level retraction.** MODE=0, MASK=0. Raise `irq_in`[3] until `int_req`=1, then drop it before any ack. Required: `int_req`=0 two cycles after the drop, state back in IDLE, no ack needed.
- **Ack/retract collision.** Mask the requested source in the same cycle as `int_ack`. Required: the ack wins and `busy`=1.
- **Set/clear collision.** In one cycle, apply a W1C on PEND[1] together with a new `irq_in`[1] rising edge. Required: PEND[1] remains 1.
- **Reset in SERVICE.** Assert `reset`=0 while `busy`=1. Required: `busy`=0 and `int_req`=0 after that edge. A later `int_eoi` is ignored.

Source files
------------

// File: rtl/mcpu_int_ctrl.sv
// Fixed-priority interrupt controller for the multi-cycle CPU: per-source mask and
// edge/level mode, latched vector, and a request / ack / end-of-interrupt handshake.
//
// Handshake: int_req rises with a latched int_vec and holds until the CPU pulses
// int_ack (request accepted, busy follows) or the source stops being eligible (retract).
// busy holds until int_eoi; int_ack outside a request and int_eoi outside service are ignored.
module mcpu_int_ctrl #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] mode_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] irq_d;

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] vec_hot;
    logic [N_SRC-1:0] pend_nxt;
    logic [VEC_W-1:0] win_idx;
    logic             any_elig;
    logic             cur_elig;
    logic             ack_ok;
    logic [31:0]      stat;
    logic             unused_wdata;

    assign elig     = pend_r & ~mask_r;
    assign any_elig = |elig;
    assign cur_elig = |(elig & vec_hot);
    assign ack_ok   = (state == ST_REQ) && int_ack;
    assign rise     = irq_in & ~irq_d;
    assign w1c      = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N_SRC-1:0] : '0;
    assign ack_clr  = ack_ok ? vec_hot : '0;

    // Edge bits: a new rising edge wins over any clear arriving in the same cycle.
    // Level bits track irq_in so that the stored value equals irq_d after the edge.
    assign pend_nxt = (mode_r & (rise | (pend_r & ~w1c & ~ack_clr))) | (~mode_r & irq_in);

    assign unused_wdata = ^cfg_wdata;

    always_comb begin
        vec_hot = '0;
        win_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec_hot[i] = (int_vec == VEC_W'(i));
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx = VEC_W'(i);
            end
        end
    end

    always_comb begin
        stat             = '0;
        stat[31]         = busy;
        stat[VEC_W-1:0]  = int_vec;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_r <= '1;
            mode_r <= '0;
            pend_r <= '0;
            irq_d  <= '0;
        end else begin
            pend_r <= pend_nxt;
            irq_d  <= irq_in;
            if (cfg_we && cfg_addr == 2'd0) begin
                mask_r <= cfg_wdata[N_SRC-1:0];
            end
            if (cfg_we && cfg_addr == 2'd1) begin
                mode_r <= cfg_wdata[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_rdata <= '0;
        end else begin
            case (cfg_addr)
                2'd0:    cfg_rdata <= 32'(mask_r);
                2'd1:    cfg_rdata <= 32'(mode_r);
                2'd2:    cfg_rdata <= 32'(pend_r);
                default: cfg_rdata <= stat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
            int_vec <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        int_vec <= win_idx;
                        int_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acceptance is checked first so an ack beats a same-cycle retraction.
                    if (int_ack) begin
                        int_req <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SERVICE;
                    end else if (!cur_elig) begin
                        int_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (int_eoi) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_int_ctrl.sv
// Bench for mcpu_int_ctrl: directed scenarios with literal checks, plus a cycle model
// of the controller compared against the DUT outputs on every falling edge.
module tb_mcpu_int_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        int_req;
    logic [2:0]  int_vec;
    logic        int_ack;
    logic        int_eoi;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mcpu_int_ctrl #(.N_SRC(8), .VEC_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in service.
    logic [7:0]  m_mask, m_mode, m_pend, m_irqd;
    int          m_phase;
    logic        m_req, m_busy, m_valid;
    logic [2:0]  m_vec;
    logic [31:0] m_rdata;

    initial begin
        m_valid = 1'b0;
        forever begin : model_step
            logic [7:0] elig;
            logic [7:0] n_pend;
            logic       edge_seen;
            logic       cleared;
            int         lo;
            @(posedge clk);
            if (!reset) begin
                m_mask = 8'hFF; m_mode = 8'h00; m_pend = 8'h00; m_irqd = 8'h00;
                m_phase = 0; m_req = 1'b0; m_busy = 1'b0; m_vec = 3'd0;
                m_rdata = 32'h0; m_valid = 1'b1;
            end else if (m_valid) begin
                elig = m_pend & ~m_mask;
                case (cfg_addr)
                    2'd0: m_rdata = {24'h0, m_mask};
                    2'd1: m_rdata = {24'h0, m_mode};
                    2'd2: m_rdata = {24'h0, m_pend};
                    default: m_rdata = (m_busy ? 32'h8000_0000 : 32'h0) + {29'h0, m_vec};
                endcase
                for (int i = 0; i < 8; i++) begin
                    if (m_mode[i]) begin
                        edge_seen = irq_in[i] && !m_irqd[i];
                        cleared = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) ||
                                  (m_phase == 1 && int_ack && int'(m_vec) == i);
                        n_pend[i] = edge_seen || (m_pend[i] && !cleared);
                    end else begin
                        n_pend[i] = irq_in[i];
                    end
                end
                if (m_phase == 0) begin
                    if (elig != 8'h00) begin
                        lo = -1;
                        for (int i = 0; i < 8; i++) begin
                            if (lo < 0 && elig[i]) lo = i;
                        end
                        m_vec = lo[2:0];
                        m_req = 1'b1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (int_ack) begin
                        m_req = 1'b0; m_busy = 1'b1; m_phase = 2;
                    end else if (!elig[m_vec]) begin
                        m_req = 1'b0; m_phase = 0;
                    end
                end else begin
                    if (int_eoi) begin
                        m_busy = 1'b0; m_phase = 0;
                    end
                end
                m_pend = n_pend;
                m_irqd = irq_in;
                if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[7:0];
                if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_wdata[7:0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_int_req", {31'h0, int_req}, {31'h0, m_req});
                check("model_int_vec", {29'h0, int_vec}, {29'h0, m_vec});
                check("model_busy", {31'h0, busy}, {31'h0, m_busy});
                check("model_cfg_rdata", cfg_rdata, m_rdata);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        step(1);
        cfg_we = 1'b0; cfg_wdata = 32'h0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        cfg_addr = addr;
        step(1);
        check(name, cfg_rdata, exp);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; step(1); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        int_eoi = 1'b1; step(1); int_eoi = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!int_req && n < budget) begin
            step(1);
            n++;
        end
        if (!int_req) check("req_timeout", {31'h0, int_req}, 32'h1);
    endtask

    initial begin
        reset = 1'b0; irq_in = 8'hFF; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 32'h0; int_ack = 1'b0; int_eoi = 1'b0;

        // Reset held for two edges with all sources high.
        step(2);
        check("reset_int_req", {31'h0, int_req}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_int_vec", {29'h0, int_vec}, 32'h0);
        check("reset_rdata", cfg_rdata, 32'h0);
        reset = 1'b1;
        cfg_read(2'd0, 32'h0000_00FF, "reset_mask");
        cfg_read(2'd2, 32'h0000_00FF, "reset_pend_level");
        check("masked_no_req", {31'h0, int_req}, 32'h0);

        // Edge priority: sources 5 and 2 pulse together.
        irq_in = 8'h00;
        cfg_write(2'd1, 32'hFF);
        cfg_write(2'd0, 32'h00);
        irq_in = 8'h24; step(1);
        irq_in = 8'h00;
        check("edge_no_req_yet", {31'h0, int_req}, 32'h0);
        step(1);
        check("edge_req", {31'h0, int_req}, 32'h1);
        check("edge_vec_first", {29'h0, int_vec}, 32'h2);
        pulse_ack();
        check("ack_req_low", {31'h0, int_req}, 32'h0);
        check("ack_busy", {31'h0, busy}, 32'h1);
        pulse_eoi();
        check("eoi_busy_low", {31'h0, busy}, 32'h0);
        check("eoi_no_req_same", {31'h0, int_req}, 32'h0);
        step(1);
        check("edge_req_second", {31'h0, int_req}, 32'h1);
        check("edge_vec_second", {29'h0, int_vec}, 32'h5);
        pulse_ack();
        pulse_eoi();
        cfg_read(2'd2, 32'h0, "edge_pend_empty");

        // Level request retracted before any ack.
        cfg_write(2'd1, 32'h00);
        irq_in = 8'h08;
        wait_req(10);
        check("level_vec", {29'h0, int_vec}, 32'h3);
        irq_in = 8'h00;
        step(1);
        check("level_still_req", {31'h0, int_req}, 32'h1);
        step(1);
        check("level_retracted", {31'h0, int_req}, 32'h0);
        check("level_not_busy", {31'h0, busy}, 32'h0);
        cfg_read(2'd3, 32'h0000_0003, "level_stat_idle");

        // Ack and mask of the requested source in the same cycle.
        irq_in = 8'h10;
        wait_req(10);
        check("collide_vec", {29'h0, int_vec}, 32'h4);
        int_ack = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h10;
        step(1);
        int_ack = 1'b0; cfg_we = 1'b0; cfg_wdata = 32'h0;
        check("collide_busy", {31'h0, busy}, 32'h1);
        check("collide_req_low", {31'h0, int_req}, 32'h0);
        cfg_read(2'd3, 32'h8000_0004, "collide_stat");
        irq_in = 8'h00;
        pulse_eoi();
        check("collide_eoi", {31'h0, busy}, 32'h0);

        // W1C on PEND[1] together with a new rising edge on source 1.
        cfg_write(2'd1, 32'hFF);
        cfg_write(2'd0, 32'h02);
        irq_in = 8'h02; step(1);
        irq_in = 8'h00; step(1);
        irq_in = 8'h02; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h02;
        step(1);
        irq_in = 8'h00; cfg_we = 1'b0; cfg_wdata = 32'h0;
        cfg_read(2'd2, 32'h0000_0002, "set_beats_clear");
        cfg_write(2'd2, 32'hFFFF_FF02);
        cfg_read(2'd2, 32'h0, "w1c_alone");

        // Reset while in service; a later eoi must do nothing.
        cfg_write(2'd0, 32'h00);
        irq_in = 8'h40; step(1);
        irq_in = 8'h00; step(1);
        check("svc_req", {31'h0, int_req}, 32'h1);
        check("svc_vec", {29'h0, int_vec}, 32'h6);
        pulse_ack();
        check("svc_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0; step(1); reset = 1'b1;
        check("svc_reset_busy", {31'h0, busy}, 32'h0);
        check("svc_reset_req", {31'h0, int_req}, 32'h0);
        pulse_eoi();
        check("svc_late_eoi", {31'h0, busy}, 32'h0);
        cfg_read(2'd0, 32'h0000_00FF, "svc_mask_reset");
        step(3);
        check("svc_final_req", {31'h0, int_req}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
